// File: rtl/ahb_mst.sv
// -----------------------------------------------------------------------------
// ahb_mst -- AHB-Lite single-transfer bus initiator.
//
// Turns a simple request/response handshake from a local requester into
// NONSEQ/SINGLE AHB transfers with non-overlapped address and data phases.
// Handles wait states and ERROR responses. Requests with an illegal size or
// misaligned address are rejected locally without any bus activity.
//
// Optional feature (compile-time macro AHB_MST_TIMEOUT_EN):
//   When defined, a tmo_w-bit wait-state counter aborts a transfer that sees
//   hready low for too long and reports it as an error. When undefined, no
//   counter is built and the initiator waits indefinitely for hready.
//
// Parameters:
//   tmo_w     width of the hready timeout counter (timeout build only)
//
// Ports:
//   hclk      clock
//   hreset    synchronous active-high reset
//   req       transfer request, held with its fields until req_ack
//   req_ack   request accepted this cycle (req while idle)
//   addr      byte address of the request
//   we        1 = write, 0 = read
//   wd        write data, lane-placed by the requester
//   size      hsize encoding (0 byte, 1 halfword, 2 word)
//   resp_vld  one-cycle completion pulse
//   rd        read data, holds until the next read completes
//   err       error flag, qualified by resp_vld
//   busy      a transfer is in progress
//   haddr, htrans, hwrite, hsize, hburst, hwdata   AHB master outputs
//   hrdata, hresp, hready                          AHB slave responses
// -----------------------------------------------------------------------------
module ahb_mst #(
    parameter int tmo_w = 8
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        req,
    output logic        req_ack,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    input  logic [2:0]  size,
    output logic        resp_vld,
    output logic [31:0] rd,
    output logic        err,
    output logic        busy,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic [1:0]  hresp,
    input  logic        hready
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        LERR
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // A zero-width counter is meaningless; catch a bad override at elaboration.
    if (tmo_w < 1) begin : g_tmo_w_check
        $error("ahb_mst: tmo_w must be at least 1");
    end

    state_e      state_q, state_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        resp_vld_q, resp_vld_d;
    logic        err_q, err_d;
    logic [31:0] rd_q, rd_d;

    logic        illegal;
    logic        tmo_hit;

    // Size above word, or an address not aligned to the transfer size.
    assign illegal = (size > 3'd2)
                   || ((size == 3'd1) && addr[0])
                   || ((size == 3'd2) && (addr[1:0] != 2'b00));

`ifdef AHB_MST_TIMEOUT_EN
    logic [tmo_w-1:0] tmo_q, tmo_d;

    // Held at zero while idle, so entry to ADDR always starts from zero and
    // completion or abort (both return to IDLE) clears it.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (((state_q == ADDR) || (state_q == DATA)) && !hready) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign tmo_hit = !hready && (tmo_q == {tmo_w{1'b1}});

    always_ff @(posedge hclk) begin
        if (hreset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // NOTE: every signal assigned below gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        htrans_d   = htrans_q;
        haddr_d    = haddr_q;
        hwrite_d   = hwrite_q;
        hsize_d    = hsize_q;
        hwdata_d   = hwdata_q;
        resp_vld_d = 1'b0;
        err_d      = err_q;
        rd_d       = rd_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (illegal) begin
                        state_d = LERR;
                    end else begin
                        state_d  = ADDR;
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = addr;
                        hwrite_d = we;
                        hsize_d  = size;
                        hwdata_d = wd;
                    end
                end
            end
            ADDR: begin
                if (tmo_hit) begin
                    state_d    = IDLE;
                    htrans_d   = HTRANS_IDLE;
                    resp_vld_d = 1'b1;
                    err_d      = 1'b1;
                end else if (hready) begin
                    state_d  = DATA;
                    htrans_d = HTRANS_IDLE;
                end
            end
            DATA: begin
                if (tmo_hit) begin
                    state_d    = IDLE;
                    resp_vld_d = 1'b1;
                    err_d      = 1'b1;
                end else if (hready) begin
                    // An ERROR response's first (hready low) cycle lands in
                    // the hold branch; only the hready-high cycle completes.
                    state_d    = IDLE;
                    resp_vld_d = 1'b1;
                    err_d      = (hresp != 2'b00);
                    if (!hwrite_q) begin
                        rd_d = hrdata;
                    end
                end
            end
            LERR: begin
                state_d    = IDLE;
                resp_vld_d = 1'b1;
                err_d      = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= IDLE;
            htrans_q   <= HTRANS_IDLE;
            haddr_q    <= '0;
            hwrite_q   <= 1'b0;
            hsize_q    <= '0;
            hwdata_q   <= '0;
            resp_vld_q <= 1'b0;
            err_q      <= 1'b0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            htrans_q   <= htrans_d;
            haddr_q    <= haddr_d;
            hwrite_q   <= hwrite_d;
            hsize_q    <= hsize_d;
            hwdata_q   <= hwdata_d;
            resp_vld_q <= resp_vld_d;
            err_q      <= err_d;
            rd_q       <= rd_d;
        end
    end

    assign req_ack  = req && (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign htrans   = htrans_q;
    assign haddr    = haddr_q;
    assign hwrite   = hwrite_q;
    assign hsize    = hsize_q;
    assign hburst   = 3'b000;
    assign hwdata   = hwdata_q;
    assign resp_vld = resp_vld_q;
    assign err      = err_q;
    assign rd       = rd_q;

endmodule

// File: doc/ahb_mst.md
# ahb_mst

AHB-Lite single-transfer bus initiator. It converts a simple request/response port from a local requester into AHB NONSEQ/SINGLE transfers with non-overlapped address and data phases. It handles wait states and ERROR responses, and it is the master-side counterpart of the team's AHB slave peripherals (TMR, etc.) inside test harnesses and DMA-style blocks.

## Interface
Parameters:
- tmo_w, 8, width of the hready wait-state timeout counter; only used when AHB_MST_TIMEOUT_EN is defined.

Ports:
- hclk  input  1  clock; the only clock.
- hreset  input  1  synchronous, active-high reset.
- req  input  1  transfer request.
- req_ack  output  1  request accepted this cycle; equals `req && (state==IDLE)`.
- addr  input  32  byte address.
- we  input  1  1 = write, 0 = read.
- wd  input  32  write data, lane-placed by the requester.
- size  input  3  hsize encoding; 0, 1, 2 are legal.
- resp_vld  output  1  one-cycle pulse marking transfer completion.
- rd  output  32  read data; valid while resp_vld is high, and holds its value until the next read completes.
- err  output  1  error flag qualified by resp_vld.
- busy  output  1  state != IDLE.
- haddr  output  32  AHB address.
- htrans  output  2  AHB transfer type; only IDLE=0 or NONSEQ=2 are driven.
- hwrite  output  1  AHB write.
- hsize  output  3  AHB size.
- hburst  output  3  constant 0 (SINGLE).
- hwdata  output  32  AHB write data.
- hrdata  input  32  AHB read data.
- hresp  input  2  AHB response; 0 = OKAY, any other value = error.
- hready  input  1  AHB ready.

## Operation
FSM states: IDLE, ADDR, DATA, LERR.

IDLE:
- req_ack = req.
- On req with a legal request, all request fields are registered and the next state is ADDR.
- On req with an illegal request, the next state is LERR.
- Illegal means size > 2, or addr misaligned to size (size 1 with addr[0] = 1; size 2 with addr[1:0] != 0).

ADDR:
- Drives htrans = NONSEQ and haddr/hwrite/hsize from the registered fields.
- If hready = 1, the next state is DATA.
- Otherwise the address phase and all its outputs are held.

DATA:
- htrans = IDLE.
- hwdata = registered wd (for writes; it is also driven for reads, where its value is don't-care).
- On hready = 1, the FSM goes to IDLE with resp_vld = 1 in that next cycle, and err = (hresp != 0).
- For reads, hrdata is captured into rd in the same cycle.
- An error's first cycle (hresp != 0, hready = 0) is ignored; completion is taken only on hready = 1.

LERR:
- No bus activity.
- Next state is IDLE with resp_vld = 1 and err = 1 in the following cycle.

General rules:
- req_ack is never asserted outside IDLE.
- A requester holds req and its fields until req_ack.
- Only one transfer is ever outstanding.
- All AHB outputs are registered, except that hburst is constant.

## Timing
Reset values (hreset sampled high):
- State = IDLE.
- htrans = 0, haddr = 0, hwrite = 0, hsize = 0, hwdata = 0.
- resp_vld = 0, err = 0, rd = 0, busy = 0, req_ack = 0.

Reset mid-transfer abandons the transfer with no resp_vld; htrans is IDLE on the next cycle.

Zero-wait transfer:
- Cycle 0: req accepted.
- Cycle 1: ADDR (NONSEQ on bus).
- Cycle 2: DATA.
- Cycle 3: resp_vld, with the FSM in IDLE, so a new req can be accepted in cycle 3.
- Throughput is one transfer per 3 cycles.

Wait states:
- Each hready = 0 cycle in ADDR or DATA adds one cycle.

Local error:
- req in cycle 0, resp_vld with err = 1 in cycle 2.

## Configuration
AHB_MST_TIMEOUT_EN:

Defined:
- A tmo_w-bit counter clears on entry to ADDR and increments on each hready = 0 cycle in ADDR/DATA.
- When it reaches 2^tmo_w - 1 with hready still 0, the FSM forces htrans = IDLE and returns to IDLE.
- The next cycle pulses resp_vld with err = 1.
- The counter clears on completion or on reset.

Undefined:
- No counter is built.
- The FSM waits indefinitely for hready.

## Test plan
- Zero-wait read: req with addr = 0x10, we = 0, size = 2, slave hrdata = 0xDEADBEEF -> NONSEQ with haddr = 0x10 in cycle 1; resp_vld in cycle 3 with rd = 0xDEADBEEF, err = 0.
- Write with 2 wait states in DATA: wd = 0x12345678, addr = 0x04 -> hwdata = 0x12345678 held for 3 cycles; resp_vld in cycle 5, err = 0.
- Two-cycle ERROR response: hresp = 1 with hready = 0, then hresp = 1 with hready = 1 -> exactly one resp_vld with err = 1; FSM back in IDLE.
- Illegal request (size = 2, addr = 0x02, or size = 3) -> htrans stays 0 throughout; resp_vld with err = 1 two cycles after req.
- Back-to-back requests with req held high -> req_ack in cycles 0 and 3; hreset asserted in a DATA cycle -> next cycle htrans = 0, busy = 0, and no resp_vld.
- With AHB_MST_TIMEOUT_EN, tmo_w = 4, hready stuck at 0 -> abort after 15 wait cycles, then resp_vld with err = 1; without the macro, no resp_vld after 1000 cycles.
